// File: rtl/ace_clk_pkg.sv
// ace_clk_pkg: shared state encoding, default divider/timing constants and width helper
package ace_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RUN
  } state_e;

  localparam int DEF_PIX_DIV         = 2;
  localparam int DEF_CPU_DIV         = 8;
  localparam int DEF_HOLD_CYCLES     = 1024;
  localparam int DEF_DEBOUNCE_CYCLES = 4096;
  localparam int DEF_SYNC_STAGES     = 2;

  // bits needed for a counter running 0..n-1; a single-value counter still gets one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_cen_gen_sync_debounce.sv
// sync_debounce: multi-flop synchroniser followed by a consecutive-cycle stability filter
module sync_debounce
  import ace_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   s, diff;

  if (SYNC_STAGES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("sync_debounce: SYNC_STAGES and DEBOUNCE_CYCLES must be >= 1");
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign diff = s != out_q;
  assign dout = out_q;

  // shift the raw input in; accept a change once it has persisted for DEBOUNCE_CYCLES cycles
  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, din});
    cnt_d  = (diff && cnt_q != CNT_LAST) ? cnt_q + 1'b1 : '0;
    out_d  = (diff && cnt_q == CNT_LAST) ? s : out_q;
  end

  // synchroniser, stability counter and accepted value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: rtl/reset_cen_gen.sv
// reset_cen_gen: system reset sequencing from PLL lock and reset button, plus pixel/CPU clock enables
module reset_cen_gen
  import ace_clk_pkg::*;
#(
  parameter int PIX_DIV         = DEF_PIX_DIV,
  parameter int CPU_DIV         = DEF_CPU_DIV,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic PLL_LOCK,
  input  logic BTN_RESET_N,
  output logic SYS_RST,
  output logic PIX_CEN,
  output logic CPU_CEN,
  output logic READY
);

  localparam int PW = cnt_width(PIX_DIV);
  localparam int CW = cnt_width(CPU_DIV);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_DIV - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  if (PIX_DIV < 1) begin : g_bad_pix
    $error("reset_cen_gen: PIX_DIV must be >= 1");
  end else if (CPU_DIV < 1 || (CPU_DIV % PIX_DIV) != 0) begin : g_bad_cpu
    $error("reset_cen_gen: CPU_DIV must be a positive multiple of PIX_DIV");
  end
  if (HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_timing
    $error("reset_cen_gen: HOLD_CYCLES/DEBOUNCE_CYCLES must be >= 1 and SYNC_STAGES >= 2");
  end

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]   cpu_cnt_q, cpu_cnt_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  logic            pix_cen_q, pix_cen_d;
  logic            cpu_cen_q, cpu_cen_d;
  logic            lock_s, btn_d;
  logic            run_q, run_d;

  // Lock path: the one-cycle filter acts as the last synchroniser flop, so lock_s
  // still sees exactly SYNC_STAGES flops of latency.
  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES - 1),
    .DEBOUNCE_CYCLES(1)
  ) u_lock (
    .clk (CLK),
    .rst (RST),
    .din (PLL_LOCK),
    .dout(lock_s)
  );

  // Button path: active-high "pressed", synchronised then debounced.
  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk (CLK),
    .rst (RST),
    .din (~BTN_RESET_N),
    .dout(btn_d)
  );

  assign run_q = state_q == RUN;
  assign run_d = state_d == RUN;

  // reset sequencing: wait for lock, hold for HOLD_CYCLES with the button released, then run
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    case (state_q)
      WAIT_LOCK: state_d = lock_s ? HOLD : WAIT_LOCK;
      HOLD: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (!btn_d && hold_cnt_q == HOLD_LAST) state_d = RUN;
        else if (!btn_d) hold_cnt_d = hold_cnt_q + 1'b1;
      end
      RUN: state_d = !lock_s ? WAIT_LOCK : (btn_d ? HOLD : RUN);
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Enables are registered alongside the state: the counters give the RUN cycle index
  // modulo each divider, and every output drops on the edge that leaves RUN.
  always_comb begin
    pix_cnt_d = (run_q && run_d) ? ((pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1) : '0;
    cpu_cnt_d = (run_q && run_d) ? ((cpu_cnt_q == CPU_LAST) ? '0 : cpu_cnt_q + 1'b1) : '0;
    pix_cen_d = run_d && pix_cnt_d == PIX_LAST;
    cpu_cen_d = run_d && cpu_cnt_d == CPU_LAST;
    sys_rst_d = !run_d;
    ready_d   = run_d;
  end

  // state, counters and registered outputs; RST forces SYS_RST high without a clock
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= WAIT_LOCK;
      hold_cnt_q <= '0;
      pix_cnt_q  <= '0;
      cpu_cnt_q  <= '0;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      pix_cen_q  <= 1'b0;
      cpu_cen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      cpu_cnt_q  <= cpu_cnt_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      pix_cen_q  <= pix_cen_d;
      cpu_cen_q  <= cpu_cen_d;
    end
  end

  assign SYS_RST = sys_rst_q;
  assign READY   = ready_q;
  assign PIX_CEN = pix_cen_q;
  assign CPU_CEN = cpu_cen_q;

endmodule
